jstk_spi_reader: RTL and testbench
==================================

JSTK_SPI_READER -- requirements
Module: jstk_spi_reader

Interface
REQ-001 Parameter HALF_DIV, default 750, clk cycles per SCLK half-period (100 MHz -> 66.67 kHz SCLK).
REQ-002 Parameter SS_SETUP_CYC, default 1500, cycles from SS falling to first SCLK low phase (15 us).
REQ-003 Parameter GAP_CYC, default 1000, idle cycles between bytes, SS held low (10 us).
REQ-004 Parameter IDLE_CYC, default 100000, cycles SS stays high between transactions (1 ms).
REQ-005 clk  in  1  system clock, 100 MHz.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 miso  in  1  serial data from Pmod JSTK.
REQ-008 led  in  2  LED request bits for the joystick.
REQ-009 ss  out  1  slave select, active-low.
REQ-010 sclk  out  1  SPI clock, mode 0, idle low.
REQ-011 mosi  out  1  SPI data to joystick.
REQ-012 x_val  out  10  latest X position, 0..1023; feeds Steering_X x input.
REQ-013 y_val  out  10  latest Y position, 0..1023.
REQ-014 buttons  out  3  latest button byte bits [2:0].
REQ-015 data_valid  out  1  one-cycle pulse when x_val/y_val/buttons update.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, LOW, HIGH, GAP, DONE.
REQ-017 IDLE: ss=1, sclk=0; after IDLE_CYC cycles -> SETUP, ss=0 from the first SETUP cycle.
REQ-018 SETUP: SHALL last SS_SETUP_CYC cycles, then -> LOW with bit counter 0, byte counter 0.
REQ-019 LOW: sclk=0 for HALF_DIV cycles; mosi SHALL present current TX bit, MSB first, stable the whole phase.
REQ-020 HIGH: sclk=1 for HALF_DIV cycles; miso SHALL be sampled into the shift register on the first HIGH cycle only.
REQ-021 After HIGH of bit 7: byte 0..3 -> GAP; byte 4 -> DONE; otherwise next bit -> LOW.
REQ-022 GAP: sclk=0, ss=0 for GAP_CYC cycles, byte counter incremented, then -> LOW.
REQ-023 Byte order received: X[7:0], X[9:8] in byte1[1:0], Y[7:0], Y[9:8] in byte3[1:0], buttons in byte4[2:0]; unused bits ignored.
REQ-024 DONE: single cycle; ss=1; x_val, y_val, buttons SHALL update and data_valid=1 in this cycle; -> IDLE.
REQ-025 Outputs x_val/y_val/buttons SHALL hold between DONE cycles; partial transactions never alter them.
REQ-026 data_valid SHALL be high exactly one cycle per completed 5-byte transaction.
REQ-027 SCLK period SHALL be exactly 2*HALF_DIV cycles; sclk, ss, mosi SHALL be registered outputs.
REQ-028 Full transaction length SHALL be SS_SETUP_CYC + 80*HALF_DIV + 4*GAP_CYC + 1 cycles of ss low, DONE included as ss high.

Reset
REQ-029 On rst: state IDLE, IDLE counter 0, ss=1, sclk=0, mosi=0, x_val=512, y_val=512, buttons=0, data_valid=0.
REQ-030 rst asserted mid-transaction SHALL abort it; next cycle ss=1, sclk=0; outputs revert to reset values.
REQ-031 After rst release the first ss falling edge SHALL occur IDLE_CYC cycles later.

Configuration
REQ-032 Macro JSTK_LED_TX_EN defined: byte 0 TX = {6'b100000, led[1:0]} (led sampled on entering SETUP), bytes 1..4 TX = 0x00.
REQ-033 Macro JSTK_LED_TX_EN undefined: mosi SHALL be constant 0; led port present but ignored.

Verification
REQ-034 Joystick model returns 0x34,0x02,0xFF,0x03,0x05 -> after DONE x_val=564, y_val=1023, buttons=3'b101, one data_valid pulse.
REQ-035 Measure sclk -> period 1500 cycles, 40 bits per transaction, 8 rising edges per byte, SETUP 1500 cycles, gaps 1000 cycles.
REQ-036 Assert rst during byte 2 -> ss high next cycle, x_val=y_val=512, no data_valid; next transaction starts 100000 cycles after release.
REQ-037 JSTK_LED_TX_EN defined, led=2'b10 -> byte 0 on mosi = 0x82, bytes 1..4 = 0x00; undefined -> mosi always 0.
REQ-038 Two back-to-back transactions with differing data -> outputs change only at each DONE; ss high gap exactly 100000 cycles (+1 DONE).

Source files
------------

// File: rtl/jstk_spi_reader.sv
// Pmod JSTK poller: clocks a 5-byte SPI mode-0 transaction, then publishes X/Y/buttons.
// Optional macro JSTK_LED_TX_EN sends the LED command in byte 0; otherwise MOSI stays 0.
//
// state | meaning
// IDLE  | ss high, waiting IDLE_CYC cycles between transactions
// SETUP | ss low, SS_SETUP_CYC cycles before the first SCLK low phase
// LOW   | sclk low half-period, mosi presents the current TX bit
// HIGH  | sclk high half-period, miso sampled on its first cycle
// GAP   | inter-byte pause with ss still low
// DONE  | single cycle, ss high, results published with data_valid
module jstk_spi_reader #(
  parameter int HALF_DIV     = 750,
  parameter int SS_SETUP_CYC = 1500,
  parameter int GAP_CYC      = 1000,
  parameter int IDLE_CYC     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       miso,
  input  logic [1:0] led,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [9:0] x_val,
  output logic [9:0] y_val,
  output logic [2:0] buttons,
  output logic       data_valid
);

  localparam int MAX_A = (HALF_DIV > SS_SETUP_CYC) ? HALF_DIV : SS_SETUP_CYC;
  localparam int MAX_B = (GAP_CYC > IDLE_CYC) ? GAP_CYC : IDLE_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] HALF_TC  = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] SETUP_TC = CW'(SS_SETUP_CYC - 1);
  localparam logic [CW-1:0] GAP_TC   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] IDLE_TC  = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    b0_q, b0_d;
  logic [1:0]    b1_q, b1_d;
  logic [7:0]    b2_q, b2_d;
  logic [1:0]    b3_q, b3_d;
  logic [9:0]    x_val_q, x_val_d;
  logic [9:0]    y_val_q, y_val_d;
  logic [2:0]    buttons_q, buttons_d;
  logic          data_valid_q, data_valid_d;
  logic          ss_q, ss_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    bit_d        = bit_q;
    byte_d       = byte_q;
    shreg_d      = shreg_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    b2_d         = b2_q;
    b3_d         = b3_q;
    x_val_d      = x_val_q;
    y_val_d      = y_val_q;
    buttons_d    = buttons_q;
    data_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cnt_q == IDLE_TC) begin
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_TC) begin
          state_d = LOW;
          cnt_d   = '0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
        end
      end
      LOW: begin
        if (cnt_q == HALF_TC) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (cnt_q == '0) shreg_d = {shreg_q[6:0], miso};
        // shreg_d is used at the exit so a one-cycle half-period still captures bit 7
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            case (byte_q)
              3'd0:    b0_d = shreg_d;
              3'd1:    b1_d = shreg_d[1:0];
              3'd2:    b2_d = shreg_d;
              3'd3:    b3_d = shreg_d[1:0];
              default: ;
            endcase
            if (byte_q == 3'd4) begin
              state_d      = DONE;
              x_val_d      = {b1_q, b0_q};
              y_val_d      = {b3_q, b2_q};
              buttons_d    = shreg_d[2:0];
              data_valid_d = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = LOW;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_TC) begin
          state_d = LOW;
          cnt_d   = '0;
          bit_d   = 3'd0;
          byte_d  = byte_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin outputs follow the next state so they are registered yet aligned with it
    ss_d   = !(state_d == SETUP || state_d == LOW || state_d == HIGH || state_d == GAP);
    sclk_d = (state_d == HIGH);
  end

`ifdef JSTK_LED_TX_EN
  logic [1:0] led_q, led_d;
  logic [7:0] tx_byte;

  always_comb begin
    led_d = led_q;
    if (state_q == IDLE && state_d == SETUP) led_d = led;
    tx_byte = (byte_d == 3'd0) ? {6'b100000, led_d} : 8'h00;
    mosi_d  = 1'b0;
    if (state_d == LOW || state_d == HIGH) mosi_d = tx_byte[3'd7 - bit_d];
  end

  always_ff @(posedge clk) begin
    if (rst) led_q <= 2'b00;
    else     led_q <= led_d;
  end
`else
  logic unused_led;
  assign unused_led = ^led;

  always_comb begin
    mosi_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      byte_q       <= 3'd0;
      shreg_q      <= 8'h00;
      b0_q         <= 8'h00;
      b1_q         <= 2'b00;
      b2_q         <= 8'h00;
      b3_q         <= 2'b00;
      x_val_q      <= 10'd512;
      y_val_q      <= 10'd512;
      buttons_q    <= 3'b000;
      data_valid_q <= 1'b0;
      ss_q         <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      shreg_q      <= shreg_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      b3_q         <= b3_d;
      x_val_q      <= x_val_d;
      y_val_q      <= y_val_d;
      buttons_q    <= buttons_d;
      data_valid_q <= data_valid_d;
      ss_q         <= ss_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
    end
  end

  assign ss         = ss_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign x_val      = x_val_q;
  assign y_val      = y_val_q;
  assign buttons    = buttons_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Directed bench for jstk_spi_reader with a behavioural Pmod JSTK slave and timing monitor.
module tb_jstk_spi_reader;

  localparam int HALF  = 4;
  localparam int SETUP = 6;
  localparam int GAPC  = 5;
  localparam int IDLEC = 20;
  localparam int SS_LOW_LEN = SETUP + 80 * HALF + 4 * GAPC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       miso = 1'b0;
  logic [1:0] led = 2'b10;
  logic       ss, sclk, mosi, data_valid;
  logic [9:0] x_val, y_val;
  logic [2:0] buttons;

  jstk_spi_reader #(
    .HALF_DIV(HALF), .SS_SETUP_CYC(SETUP), .GAP_CYC(GAPC), .IDLE_CYC(IDLEC)
  ) dut (
    .clk(clk), .rst(rst), .miso(miso), .led(led),
    .ss(ss), .sclk(sclk), .mosi(mosi),
    .x_val(x_val), .y_val(y_val), .buttons(buttons), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // slave payload and monitor state
  logic [7:0]  slv [5];
  int          k, n_rise, byte_no, bad_period, bad_gap, setup_meas;
  int          rises_in_byte [8];
  int          ss_fall_cyc = 0, ss_rise_cyc = -1, ss_low_len = 0, ss_gap = 0;
  int          ss_fall_count = 0, prev_rise_cyc = 0;
  int          dv_total = 0, dv_long = 0, illegal_chg = 0;
  logic [39:0] mosi_bits;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_dv = 1'b0;
  logic [9:0]  px = 10'd512, py = 10'd512;
  logic [2:0]  pb = 3'd0;

  always @(negedge clk) begin
    if (!ss && prev_ss) begin
      ss_fall_cyc = cyc;
      ss_fall_count++;
      if (ss_rise_cyc >= 0) ss_gap = cyc - ss_rise_cyc;
      k = 0; n_rise = 0; byte_no = -1; bad_period = 0; bad_gap = 0;
      mosi_bits = '0;
      for (int i = 0; i < 8; i++) rises_in_byte[i] = 0;
      miso = slv[0][7];
    end
    if (ss && !prev_ss) begin
      ss_rise_cyc = cyc;
      ss_low_len  = cyc - ss_fall_cyc;
    end
    if (!ss && sclk && !prev_sclk) begin
      if (n_rise == 0) begin
        setup_meas = cyc - ss_fall_cyc;
        byte_no    = 0;
      end else if (cyc - prev_rise_cyc > 2 * HALF) begin
        byte_no++;
        if (cyc - prev_rise_cyc != 2 * HALF + GAPC) bad_gap++;
      end else if (cyc - prev_rise_cyc != 2 * HALF) begin
        bad_period++;
      end
      if (byte_no >= 0 && byte_no < 8) rises_in_byte[byte_no]++;
      if (n_rise < 40) mosi_bits[39 - n_rise] = mosi;
      n_rise++;
      prev_rise_cyc = cyc;
    end
    if (!sclk && prev_sclk) begin
      k++;
      miso = (k < 40) ? slv[k / 8][7 - (k % 8)] : 1'b0;
    end
    if (data_valid) dv_total++;
    if (data_valid && prev_dv) dv_long++;
    if (!rst && !data_valid && (x_val !== px || y_val !== py || buttons !== pb)) illegal_chg++;
    px = x_val; py = y_val; pb = buttons;
    prev_ss = ss; prev_sclk = sclk; prev_dv = data_valid;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (data_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_ss_fall(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (ss_fall_count >= target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int rel;
    bit ok;
    slv[0] = 8'h34; slv[1] = 8'h02; slv[2] = 8'hFF; slv[3] = 8'h03; slv[4] = 8'h05;
    rst = 1'b1;
    repeat (3) tick();
    n_vec++; if (ss !== 1'b1)      begin n_err++; $display("FAIL rst_ss got %b want 1", ss); end
    n_vec++; if (sclk !== 1'b0)    begin n_err++; $display("FAIL rst_sclk got %b want 0", sclk); end
    n_vec++; if (mosi !== 1'b0)    begin n_err++; $display("FAIL rst_mosi got %b want 0", mosi); end
    n_vec++; if (x_val !== 10'd512) begin n_err++; $display("FAIL rst_x got %0d want 512", x_val); end
    n_vec++; if (y_val !== 10'd512) begin n_err++; $display("FAIL rst_y got %0d want 512", y_val); end
    n_vec++; if (buttons !== 3'd0) begin n_err++; $display("FAIL rst_buttons got %b want 000", buttons); end
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_dv got %b want 0", data_valid); end
    rst = 1'b0;
    rel = cyc;
    wait_ss_fall(1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rst_first_ss_fall timeout want fall"); end
    else if (ss_fall_cyc - rel != IDLEC) begin
      n_err++; $display("FAIL rst_first_ss_fall got %0d want %0d", ss_fall_cyc - rel, IDLEC);
    end
  endtask

  task automatic test_transaction();
    bit ok;
    int bad_bytes;
    logic [7:0] exp_b0;
`ifdef JSTK_LED_TX_EN
    exp_b0 = 8'h82;
`else
    exp_b0 = 8'h00;
`endif
    wait_dv(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL txn_dv timeout want pulse"); end
    n_vec++; if (x_val !== 10'd564)  begin n_err++; $display("FAIL txn_x got %0d want 564", x_val); end
    n_vec++; if (y_val !== 10'd1023) begin n_err++; $display("FAIL txn_y got %0d want 1023", y_val); end
    n_vec++; if (buttons !== 3'b101) begin n_err++; $display("FAIL txn_buttons got %b want 101", buttons); end
    n_vec++; if (ss !== 1'b1) begin n_err++; $display("FAIL txn_done_ss got %b want 1", ss); end
    n_vec++; if (n_rise != 40) begin n_err++; $display("FAIL txn_rises got %0d want 40", n_rise); end
    n_vec++; if (bad_period != 0) begin n_err++; $display("FAIL txn_period bad %0d want 0 (period %0d)", bad_period, 2 * HALF); end
    n_vec++; if (bad_gap != 0) begin n_err++; $display("FAIL txn_gap bad %0d want 0", bad_gap); end
    n_vec++; if (setup_meas != SETUP + HALF) begin n_err++; $display("FAIL txn_setup got %0d want %0d", setup_meas, SETUP + HALF); end
    n_vec++; if (byte_no != 4) begin n_err++; $display("FAIL txn_bytes got %0d want 4", byte_no); end
    bad_bytes = 0;
    for (int i = 0; i < 5; i++) if (rises_in_byte[i] != 8) bad_bytes++;
    n_vec++; if (bad_bytes != 0) begin n_err++; $display("FAIL txn_rises_per_byte bad %0d want 0", bad_bytes); end
    n_vec++; if (ss_low_len != SS_LOW_LEN) begin n_err++; $display("FAIL txn_ss_low got %0d want %0d", ss_low_len, SS_LOW_LEN); end
    n_vec++; if (mosi_bits[39:32] !== exp_b0) begin n_err++; $display("FAIL txn_mosi_b0 got %h want %h", mosi_bits[39:32], exp_b0); end
    n_vec++; if (mosi_bits[31:0] !== 32'h0) begin n_err++; $display("FAIL txn_mosi_rest got %h want 0", mosi_bits[31:0]); end
    slv[0] = 8'h00; slv[1] = 8'h01; slv[2] = 8'h80; slv[3] = 8'h00; slv[4] = 8'h02;
    tick();
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL txn_dv_width got %b want 0", data_valid); end
    n_vec++; if (dv_total != 1) begin n_err++; $display("FAIL txn_dv_count got %0d want 1", dv_total); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_dv(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b1_dv timeout want pulse"); end
    n_vec++; if (x_val !== 10'd256) begin n_err++; $display("FAIL b2b1_x got %0d want 256", x_val); end
    n_vec++; if (y_val !== 10'd128) begin n_err++; $display("FAIL b2b1_y got %0d want 128", y_val); end
    n_vec++; if (buttons !== 3'b010) begin n_err++; $display("FAIL b2b1_buttons got %b want 010", buttons); end
    n_vec++; if (ss_gap != IDLEC + 1) begin n_err++; $display("FAIL b2b1_ss_gap got %0d want %0d", ss_gap, IDLEC + 1); end
    slv[0] = 8'hFF; slv[1] = 8'hFE; slv[2] = 8'h01; slv[3] = 8'h01; slv[4] = 8'h07;
    wait_dv(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b2_dv timeout want pulse"); end
    n_vec++; if (x_val !== 10'd767) begin n_err++; $display("FAIL b2b2_x got %0d want 767", x_val); end
    n_vec++; if (y_val !== 10'd257) begin n_err++; $display("FAIL b2b2_y got %0d want 257", y_val); end
    n_vec++; if (buttons !== 3'b111) begin n_err++; $display("FAIL b2b2_buttons got %b want 111", buttons); end
    n_vec++; if (ss_gap != IDLEC + 1) begin n_err++; $display("FAIL b2b2_ss_gap got %0d want %0d", ss_gap, IDLEC + 1); end
    n_vec++; if (ss_low_len != SS_LOW_LEN) begin n_err++; $display("FAIL b2b2_ss_low got %0d want %0d", ss_low_len, SS_LOW_LEN); end
    n_vec++; if (illegal_chg != 0) begin n_err++; $display("FAIL b2b_hold got %0d changes want 0", illegal_chg); end
    n_vec++; if (dv_long != 0) begin n_err++; $display("FAIL b2b_dv_width got %0d long want 0", dv_long); end
    n_vec++; if (dv_total != 3) begin n_err++; $display("FAIL b2b_dv_count got %0d want 3", dv_total); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int dv_before, falls_before, rel;
    slv[0] = 8'h10; slv[1] = 8'h03; slv[2] = 8'h20; slv[3] = 8'h02; slv[4] = 8'h01;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (!ss && byte_no == 2) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL abort_reach_byte2 timeout want byte 2"); end
    dv_before    = dv_total;
    falls_before = ss_fall_count;
    rst = 1'b1;
    tick();
    n_vec++; if (ss !== 1'b1)       begin n_err++; $display("FAIL abort_ss got %b want 1", ss); end
    n_vec++; if (sclk !== 1'b0)     begin n_err++; $display("FAIL abort_sclk got %b want 0", sclk); end
    n_vec++; if (x_val !== 10'd512) begin n_err++; $display("FAIL abort_x got %0d want 512", x_val); end
    n_vec++; if (y_val !== 10'd512) begin n_err++; $display("FAIL abort_y got %0d want 512", y_val); end
    n_vec++; if (buttons !== 3'd0)  begin n_err++; $display("FAIL abort_buttons got %b want 000", buttons); end
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL abort_dv got %b want 0", data_valid); end
    rst = 1'b0;
    rel = cyc;
    wait_ss_fall(falls_before + 1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL abort_restart timeout want fall"); end
    else if (ss_fall_cyc - rel != IDLEC) begin
      n_err++; $display("FAIL abort_restart got %0d want %0d", ss_fall_cyc - rel, IDLEC);
    end
    n_vec++; if (dv_total != dv_before) begin n_err++; $display("FAIL abort_no_dv got %0d want %0d", dv_total, dv_before); end
    wait_dv(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL abort_next_dv timeout want pulse"); end
    n_vec++; if (x_val !== 10'd784) begin n_err++; $display("FAIL abort_next_x got %0d want 784", x_val); end
    n_vec++; if (y_val !== 10'd544) begin n_err++; $display("FAIL abort_next_y got %0d want 544", y_val); end
    n_vec++; if (buttons !== 3'b001) begin n_err++; $display("FAIL abort_next_buttons got %b want 001", buttons); end
  endtask

  initial begin
    test_reset();
    test_transaction();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
